mc_control_unit: RTL and testbench

Multi-cycle control FSM that drives the ALU's `alu_op` input and consumes its `alu_bcond` output. It sequences a single shared ALU and a single shared memory port through IF/ID/EX/MEM/WB for the RV32I subset the ALU supports. It sits between the instruction register and the multi-cycle datapath muxes, and emits every datapath enable and select.

---
 rtl/ctrl_pkg.sv | 79 +++++++
 rtl/mc_control_unit_if.sv | 34 +++
 rtl/alu_op_decoder.sv | 50 +++++
 rtl/mc_control_unit.sv | 142 ++++++++++++++
 tb/tb_mc_control_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit: FSM states,
// ALU operation encodings, opcode values and datapath select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_AND = 5'd1,
    ALU_OR  = 5'd2,
    ALU_XOR = 5'd3,
    ALU_SLL = 5'd4,
    ALU_SRL = 5'd5,
    ALU_SUB = 5'd6,
    ALU_BEQ = 5'd7,
    ALU_BNE = 5'd8,
    ALU_BLT = 5'd9,
    ALU_BGE = 5'd10
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_PC4    = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ECALL,
    CLS_UNKNOWN
  } instr_cls_e;

  function automatic instr_cls_e decode_cls(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_IMM:    return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_SYSTEM: return CLS_ECALL;
      default:   return CLS_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Bundle between the control unit (master) and the multi-cycle datapath
// (slave): decoded IR fields and status in, every enable and select out.
interface mc_control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_bcond;
  logic       mem_ready;

  logic [4:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       pc_write;
  logic [1:0] pc_source;
  logic [1:0] mem_to_reg;
  logic       is_halted;

  modport master (
    input  opcode, funct3, funct7_5, alu_bcond, mem_ready,
    output alu_op, alu_src_a, alu_src_b, ir_write, mem_read, mem_write,
           i_or_d, reg_write, pc_write, pc_source, mem_to_reg, is_halted
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_bcond, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, ir_write, mem_read, mem_write,
           i_or_d, reg_write, pc_write, pc_source, mem_to_reg, is_halted
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation select: ADD everywhere except EX, where the
// instruction class and funct3/funct7_5 pick the arithmetic or compare op.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  state_e     state,
  output alu_op_e    alu_op
);

  // funct3 010/011 have no ALU encoding of their own and decode to ADD.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b001:  return ALU_SLL;
      3'b101:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic alu_op_e branch_op(input logic [2:0] f3);
    case (f3)
      3'b000:         return ALU_BEQ;
      3'b001:         return ALU_BNE;
      3'b100, 3'b110: return ALU_BLT;
      3'b101, 3'b111: return ALU_BGE;
      default:        return ALU_BEQ;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    alu_op = ALU_ADD;
    if (state == S_EX) begin
      case (decode_cls(opcode))
        CLS_R:      alu_op = arith_op(funct3, funct7_5);
        CLS_I:      alu_op = arith_op(funct3, 1'b0);
        CLS_BRANCH: alu_op = branch_op(funct3);
        default:    alu_op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the RV32I subset of the shared ALU.
// Build option: define CTRL_ECALL_HALT_EN to make ECALL halt the core.
module mc_control_unit
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_control_unit_if.master bus
);

  state_e     state_q, state_d;
  instr_cls_e raw_cls, cls;
  alu_op_e    alu_op_dec;

  assign raw_cls = decode_cls(bus.opcode);

`ifdef CTRL_ECALL_HALT_EN
  assign cls = raw_cls;
`else
  assign cls = (raw_cls == CLS_ECALL) ? CLS_UNKNOWN : raw_cls;
`endif

  alu_op_decoder u_alu_op_decoder (
    .opcode   (bus.opcode),
    .funct3   (bus.funct3),
    .funct7_5 (bus.funct7_5),
    .state    (state_q),
    .alu_op   (alu_op_dec)
  );

  // The state sits in IF while reset is held, so the decoder already yields ADD (0).
  assign bus.alu_op = alu_op_dec;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        case (cls)
          CLS_JAL:     state_d = S_WB;
          CLS_ECALL:   state_d = S_HALT;
          CLS_UNKNOWN: state_d = S_IF;
          default:     state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_BRANCH:          state_d = S_IF;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM: if (bus.mem_ready) state_d = (cls == CLS_LOAD) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Outputs are forced low while reset is held, even though the state reads IF.
  always_comb begin
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_source  = PC_SRC_ALU;
    bus.mem_to_reg = WB_ALUOUT;
    bus.is_halted  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
        end
        S_ID: begin
          bus.alu_src_a = SRC_A_PC;
          bus.alu_src_b = SRC_B_IMM;
          if (cls == CLS_UNKNOWN) begin
            bus.pc_write  = 1'b1;
            bus.pc_source = PC_SRC_PC4;
          end
        end
        S_EX: begin
          bus.alu_src_a = SRC_A_RS1;
          case (cls)
            CLS_R: bus.alu_src_b = SRC_B_RS2;
            CLS_BRANCH: begin
              bus.alu_src_b = SRC_B_RS2;
              bus.pc_write  = 1'b1;
              bus.pc_source = bus.alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
            end
            default: bus.alu_src_b = SRC_B_IMM;
          endcase
        end
        S_MEM: begin
          bus.i_or_d = 1'b1;
          if (cls == CLS_LOAD) begin
            bus.mem_read = 1'b1;
          end else begin
            // A store finishes here; PC advances only on the completing cycle.
            bus.mem_write = 1'b1;
            bus.pc_write  = bus.mem_ready;
            bus.pc_source = PC_SRC_PC4;
          end
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          case (cls)
            CLS_LOAD: begin
              bus.mem_to_reg = WB_MDR;
              bus.pc_source  = PC_SRC_PC4;
            end
            CLS_JAL, CLS_JALR: begin
              bus.mem_to_reg = WB_PC4;
              bus.pc_source  = PC_SRC_ALUOUT;
            end
            default: bus.pc_source = PC_SRC_PC4;
          endcase
        end
        S_HALT: begin
`ifdef CTRL_ECALL_HALT_EN
          bus.is_halted = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle output vectors are written out
// by hand for each instruction class, stall pattern and reset scenario.
module tb_mc_control_unit;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic [1:0] mem_to_reg;
    logic       is_halted;
  } ctl_t;

  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic ctl_t obs();
    ctl_t o;
    o.alu_op     = bus.alu_op;
    o.src_a      = bus.alu_src_a;
    o.src_b      = bus.alu_src_b;
    o.ir_write   = bus.ir_write;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.i_or_d     = bus.i_or_d;
    o.reg_write  = bus.reg_write;
    o.pc_write   = bus.pc_write;
    o.pc_source  = bus.pc_source;
    o.mem_to_reg = bus.mem_to_reg;
    o.is_halted  = bus.is_halted;
    return o;
  endfunction

  function automatic ctl_t c_if(input logic rdy);
    ctl_t e = '0;
    e.mem_read = 1'b1;
    e.ir_write = rdy;
    return e;
  endfunction

  function automatic ctl_t c_id();
    ctl_t e = '0;
    e.src_b = 2'd1;
    return e;
  endfunction

  function automatic ctl_t c_ex(input logic [4:0] op, input logic [1:0] b);
    ctl_t e = '0;
    e.alu_op = op;
    e.src_a  = 2'd1;
    e.src_b  = b;
    return e;
  endfunction

  function automatic ctl_t c_wb(input logic [1:0] m2r, input logic [1:0] pcs);
    ctl_t e = '0;
    e.reg_write  = 1'b1;
    e.pc_write   = 1'b1;
    e.mem_to_reg = m2r;
    e.pc_source  = pcs;
    return e;
  endfunction

  function automatic ctl_t c_mem(input logic is_load, input logic rdy);
    ctl_t e = '0;
    e.i_or_d = 1'b1;
    if (is_load) begin
      e.mem_read = 1'b1;
    end else begin
      e.mem_write = 1'b1;
      e.pc_write  = rdy;
      e.pc_source = 2'd2;
    end
    return e;
  endfunction

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f75;
  endtask

  // Drive this cycle's inputs just after the falling edge and let them settle.
  task automatic apply(input logic rdy, input logic bc);
    bus.mem_ready = rdy;
    bus.alu_bcond = bc;
    #3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ir(7'h33, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    bus.alu_bcond = 1'b1;
    #3;
    tests++;
    if (obs() !== ctl_t'(0)) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), ctl_t'(0));
    end
    @(negedge clk);
    apply(1'b1, 1'b1);
    tests++;
    if (obs() !== ctl_t'(0)) begin
      fails++;
      $display("FAIL reset_after_edge: got %h expected %h", obs(), ctl_t'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 1'b0);
    tests++;
    if (obs() !== c_if(1'b0)) begin
      fails++;
      $display("FAIL reset_release_if: got %h expected %h", obs(), c_if(1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_rtype_sub();
    ctl_t exp [4];
    exp[0] = c_if(1'b1);
    exp[1] = c_id();
    exp[2] = c_ex(5'd6, 2'd0);
    exp[3] = c_wb(2'd0, 2'd2);
    set_ir(7'h33, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL rtype_sub cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_stall();
    ctl_t exp [8];
    logic rdy [8];
    int   pc_pulses = 0;
    int   ir_pulses = 0;
    ctl_t o;
    exp[0] = c_if(1'b1);        rdy[0] = 1'b1;
    exp[1] = c_id();            rdy[1] = 1'b1;
    exp[2] = c_ex(5'd0, 2'd1);  rdy[2] = 1'b1;
    exp[3] = c_mem(1'b1, 1'b0); rdy[3] = 1'b0;
    exp[4] = c_mem(1'b1, 1'b0); rdy[4] = 1'b0;
    exp[5] = c_mem(1'b1, 1'b0); rdy[5] = 1'b0;
    exp[6] = c_mem(1'b1, 1'b1); rdy[6] = 1'b1;
    exp[7] = c_wb(2'd1, 2'd2);  rdy[7] = 1'b1;
    set_ir(7'h03, 3'b010, 1'b0);
    for (int i = 0; i < 8; i++) begin
      apply(rdy[i], 1'b0);
      o = obs();
      pc_pulses += int'(o.pc_write);
      ir_pulses += int'(o.ir_write);
      tests++;
      if (o !== exp[i]) begin
        fails++;
        $display("FAIL load_stall cyc%0d: got %h expected %h", i, o, exp[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (pc_pulses !== 1 || ir_pulses !== 1) begin
      fails++;
      $display("FAIL load_pulses: got pc_write %0d ir_write %0d expected 1 and 1",
               pc_pulses, ir_pulses);
    end
  endtask

  task automatic test_store();
    ctl_t exp [5];
    logic rdy [5];
    exp[0] = c_if(1'b1);        rdy[0] = 1'b1;
    exp[1] = c_id();            rdy[1] = 1'b1;
    exp[2] = c_ex(5'd0, 2'd1);  rdy[2] = 1'b1;
    exp[3] = c_mem(1'b0, 1'b0); rdy[3] = 1'b0;
    exp[4] = c_mem(1'b0, 1'b1); rdy[4] = 1'b1;
    set_ir(7'h23, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(rdy[i], 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL store cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [8] = '{3'b001, 3'b001, 3'b000, 3'b110, 3'b101, 3'b111, 3'b010, 3'b100};
    logic       bcs [8] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
    logic [4:0] ops [8] = '{5'd8,   5'd8,   5'd7,   5'd9,   5'd10,  5'd10,  5'd7,   5'd9};
    ctl_t exp [3];
    for (int r = 0; r < 8; r++) begin
      exp[0] = c_if(1'b1);
      exp[1] = c_id();
      exp[2] = c_ex(ops[r], 2'd0);
      exp[2].pc_write  = 1'b1;
      exp[2].pc_source = bcs[r] ? 2'd1 : 2'd2;
      set_ir(7'h63, f3s[r], 1'b0);
      for (int i = 0; i < 3; i++) begin
        apply(1'b1, bcs[r]);
        tests++;
        if (obs() !== exp[i]) begin
          fails++;
          $display("FAIL branch row%0d cyc%0d: got %h expected %h", r, i, obs(), exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jal();
    ctl_t exp [4];
    logic rdy [4];
    exp[0] = c_if(1'b0);       rdy[0] = 1'b0;
    exp[1] = c_if(1'b1);       rdy[1] = 1'b1;
    exp[2] = c_id();           rdy[2] = 1'b1;
    exp[3] = c_wb(2'd2, 2'd1); rdy[3] = 1'b1;
    set_ir(7'h6F, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(rdy[i], 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL jal cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jalr();
    ctl_t exp [4];
    exp[0] = c_if(1'b1);
    exp[1] = c_id();
    exp[2] = c_ex(5'd0, 2'd1);
    exp[3] = c_wb(2'd2, 2'd1);
    set_ir(7'h67, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL jalr cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] opc [9] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h13, 7'h13};
    logic [2:0] f3s [9] = '{3'b111, 3'b110, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b101, 3'b111};
    logic       f7s [9] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    logic [4:0] ops [9] = '{5'd1,   5'd2,   5'd4,   5'd5,   5'd0,   5'd0,   5'd3,   5'd5,   5'd1};
    logic [1:0] bs  [9] = '{2'd0,   2'd0,   2'd0,   2'd0,   2'd0,   2'd1,   2'd1,   2'd1,   2'd1};
    ctl_t exp [4];
    for (int r = 0; r < 9; r++) begin
      exp[0] = c_if(1'b1);
      exp[1] = c_id();
      exp[2] = c_ex(ops[r], bs[r]);
      exp[3] = c_wb(2'd0, 2'd2);
      set_ir(opc[r], f3s[r], f7s[r]);
      for (int i = 0; i < 4; i++) begin
        apply(1'b1, 1'b0);
        tests++;
        if (obs() !== exp[i]) begin
          fails++;
          $display("FAIL alu_decode row%0d cyc%0d: got %h expected %h", r, i, obs(), exp[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_unknown();
    ctl_t exp [3];
    logic rdy [3];
    exp[0] = c_if(1'b1); rdy[0] = 1'b1;
    exp[1] = c_id();     rdy[1] = 1'b1;
    exp[1].pc_write  = 1'b1;
    exp[1].pc_source = 2'd2;
    exp[2] = c_if(1'b0); rdy[2] = 1'b0;
    set_ir(7'h37, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(rdy[i], 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL unknown cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_if_stall();
    set_ir(7'h33, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0);
      tests++;
      if (obs() !== c_if(1'b0)) begin
        fails++;
        $display("FAIL if_stall cyc%0d: got %h expected %h", i, obs(), c_if(1'b0));
      end
      if (i == 0) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (obs() !== ctl_t'(0)) begin
      fails++;
      $display("FAIL if_stall_reset: got %h expected %h", obs(), ctl_t'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 1'b0);
    tests++;
    if (obs() !== c_if(1'b0)) begin
      fails++;
      $display("FAIL if_stall_restart: got %h expected %h", obs(), c_if(1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mem_stall();
    ctl_t exp [5];
    logic rdy [5];
    exp[0] = c_if(1'b1);        rdy[0] = 1'b1;
    exp[1] = c_id();            rdy[1] = 1'b1;
    exp[2] = c_ex(5'd0, 2'd1);  rdy[2] = 1'b1;
    exp[3] = c_mem(1'b1, 1'b0); rdy[3] = 1'b0;
    exp[4] = c_mem(1'b1, 1'b0); rdy[4] = 1'b0;
    set_ir(7'h03, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(rdy[i], 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL mem_stall cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (obs() !== ctl_t'(0)) begin
      fails++;
      $display("FAIL mem_stall_reset: got %h expected %h", obs(), ctl_t'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 1'b0);
    tests++;
    if (obs() !== c_if(1'b0)) begin
      fails++;
      $display("FAIL mem_stall_restart: got %h expected %h", obs(), c_if(1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_ecall();
    ctl_t exp [5];
    int   n;
    exp[0] = c_if(1'b1);
    exp[1] = c_id();
`ifdef CTRL_ECALL_HALT_EN
    n = 5;
    for (int i = 2; i < 5; i++) begin
      exp[i] = '0;
      exp[i].is_halted = 1'b1;
    end
`else
    n = 3;
    exp[1].pc_write  = 1'b1;
    exp[1].pc_source = 2'd2;
    exp[2] = c_if(1'b1);
`endif
    set_ir(7'h73, 3'b000, 1'b0);
    for (int i = 0; i < n; i++) begin
      apply(1'b1, 1'b0);
      tests++;
      if (obs() !== exp[i]) begin
        fails++;
        $display("FAIL ecall cyc%0d: got %h expected %h", i, obs(), exp[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.opcode    = 7'h00;
    bus.funct3    = 3'b000;
    bus.funct7_5  = 1'b0;
    bus.mem_ready = 1'b0;
    bus.alu_bcond = 1'b0;
    test_reset();
    test_rtype_sub();
    test_load_stall();
    test_store();
    test_branch();
    test_jal();
    test_jalr();
    test_alu_decode();
    test_unknown();
    test_reset_if_stall();
    test_reset_mem_stall();
    test_ecall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
